// File: rtl/dlsc_dcm_reprog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dlsc_dcm_reprog_pkg : clock-generator register map, sequencer states and
//                       error codes shared by the DCM reprogramming sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package dlsc_dcm_reprog_pkg;

  localparam logic [7:0] OFF_CONTROL  = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_MULTIPLY = 8'h10;
  localparam logic [7:0] OFF_DIVIDE   = 8'h14;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_INVALID = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RSTIN   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CHECK    = 4'd1,
    ST_WR_DIS   = 4'd2,
    ST_POLL_DIS = 4'd3,
    ST_WR_MULT  = 4'd4,
    ST_WR_DIV   = 4'd5,
    ST_WR_EN    = 4'd6,
    ST_POLL_EN  = 4'd7,
    ST_DONE     = 4'd8,
    ST_ERR      = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dlsc_apb_mstr_xfer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dlsc_apb_mstr_xfer : single-transaction APB master (setup, access, idle).
// Revision: 1.0
// ---------------------------------------------------------------------------
module dlsc_apb_mstr_xfer #(
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            write,
  input  logic [ADDR-1:0] addr,
  input  logic [31:0]     wdata,
  output logic            xfer_done,
  output logic [31:0]     rdata,
  output logic [ADDR-1:0] apb_addr,
  output logic            apb_sel,
  output logic            apb_enable,
  output logic            apb_write,
  output logic [31:0]     apb_wdata,
  output logic [3:0]      apb_strb,
  input  logic            apb_ready,
  input  logic [31:0]     apb_rdata
);

  // start is honoured only when the bus is idle; the completion cycle doubles
  // as the mandatory idle cycle between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_done  <= 1'b0;
      rdata      <= '0;
      apb_addr   <= '0;
      apb_sel    <= 1'b0;
      apb_enable <= 1'b0;
      apb_write  <= 1'b0;
      apb_wdata  <= '0;
      apb_strb   <= '0;
    end else begin
      xfer_done <= 1'b0;
      if (apb_sel && apb_enable) begin
        if (apb_ready) begin
          apb_sel    <= 1'b0;
          apb_enable <= 1'b0;
          xfer_done  <= 1'b1;
          rdata      <= apb_rdata;
        end
      end else if (apb_sel) begin
        apb_enable <= 1'b1;
      end else if (start) begin
        apb_sel   <= 1'b1;
        apb_addr  <= addr;
        apb_write <= write;
        apb_wdata <= wdata;
        apb_strb  <= write ? 4'hF : 4'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlsc_dcm_reprog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dlsc_dcm_reprog : reprograms the DCM clock generator M/D over APB
//                   (disable, write M/D, enable, wait ready) per command.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dlsc_dcm_reprog
  import dlsc_dcm_reprog_pkg::*;
#(
  parameter int              ADDR     = 32,
  parameter logic [ADDR-1:0] BASE     = '0,
  parameter int              MD_MAX   = 4,
  parameter int              POLL_GAP = 15,
  parameter int              TIMEOUT  = 65535
) (
  input  logic            apb_clk,
  input  logic            apb_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [7:0]      cmd_mult,
  input  logic [7:0]      cmd_div,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [ADDR-1:0] apb_addr,
  output logic            apb_sel,
  output logic            apb_enable,
  output logic            apb_write,
  output logic [31:0]     apb_wdata,
  output logic [3:0]      apb_strb,
  input  logic            apb_ready,
  input  logic [31:0]     apb_rdata
);

  localparam int CW = 9 + $clog2(MD_MAX) + 1;

  state_t      r_state, w_next;
  logic [7:0]  r_mult, r_div;
  logic        r_pend;
  logic [7:0]  r_gap;
  logic [19:0] r_tcnt;

  logic        w_start, w_write, w_xfer_done, w_invalid, w_timeout;
  logic [7:0]  w_off;
  logic [31:0] w_wdata, w_rdata;
  logic [1:0]  w_code;
  logic [CW-1:0] w_m_plus1, w_lim;

  assign w_m_plus1 = CW'(r_mult) + CW'(1);
  assign w_lim     = CW'(MD_MAX) * (CW'(r_div) + CW'(1));
  assign w_invalid = (r_mult == 8'd0) || (w_m_plus1 > w_lim);
  assign w_timeout = (r_tcnt >= 20'(TIMEOUT));

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_write = 1'b0;
    w_off   = OFF_CONTROL;
    w_wdata = '0;
    w_code  = ERR_NONE;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_invalid) begin
          w_next = ST_ERR;
          w_code = ERR_INVALID;
        end else begin
          w_next  = ST_WR_DIS;
          w_start = 1'b1;
          w_write = 1'b1;
        end
      end
      ST_WR_DIS: if (w_xfer_done) begin
        w_next  = ST_POLL_DIS;
        w_start = 1'b1;
        w_off   = OFF_STATUS;
      end
      ST_WR_MULT: if (w_xfer_done) begin
        w_next  = ST_WR_DIV;
        w_start = 1'b1;
        w_write = 1'b1;
        w_off   = OFF_DIVIDE;
        w_wdata = {24'd0, r_div};
      end
      ST_WR_DIV: if (w_xfer_done) begin
        w_next  = ST_WR_EN;
        w_start = 1'b1;
        w_write = 1'b1;
        w_wdata = 32'd1;
      end
      ST_WR_EN: if (w_xfer_done) begin
        w_next  = ST_POLL_EN;
        w_start = 1'b1;
        w_off   = OFF_STATUS;
      end
      ST_POLL_DIS, ST_POLL_EN: begin
        // A returned status is judged before the timeout, so a read already
        // in flight when the budget expires can still complete the sequence.
        if (w_xfer_done) begin
          if (r_state == ST_POLL_DIS && !w_rdata[0]) begin
            w_next  = ST_WR_MULT;
            w_start = 1'b1;
            w_write = 1'b1;
            w_off   = OFF_MULTIPLY;
            w_wdata = {24'd0, r_mult};
          end else if (r_state == ST_POLL_EN && w_rdata[1]) begin
            w_next = ST_ERR;
            w_code = ERR_RSTIN;
          end else if (r_state == ST_POLL_EN && w_rdata[0]) begin
            w_next = ST_DONE;
          end else if (w_timeout) begin
            w_next = ST_ERR;
            w_code = ERR_TIMEOUT;
          end
        end else if (!r_pend) begin
          if (w_timeout) begin
            w_next = ST_ERR;
            w_code = ERR_TIMEOUT;
          end else if (r_gap == 8'd0) begin
            w_start = 1'b1;
            w_off   = OFF_STATUS;
          end
        end
      end
      ST_DONE, ST_ERR: w_next = ST_IDLE;
      default:         w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_state   <= ST_IDLE;
      r_mult    <= '0;
      r_div     <= '0;
      r_pend    <= 1'b0;
      r_gap     <= '0;
      r_tcnt    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_mult <= cmd_mult;
        r_div  <= cmd_div;
      end
      r_pend <= w_start ? 1'b1 : (w_xfer_done ? 1'b0 : r_pend);
      if (w_xfer_done)
        r_gap <= 8'(POLL_GAP);
      else if (!r_pend && r_gap != 8'd0)
        r_gap <= r_gap - 8'd1;
      // Cleared on every state change, so each poll state starts from zero.
      r_tcnt    <= (w_next != r_state) ? '0 : (w_timeout ? r_tcnt : r_tcnt + 20'd1);
      cmd_ready <= (w_next == ST_IDLE);
      busy      <= (w_next != ST_IDLE);
      done      <= (w_next == ST_DONE);
      err       <= (w_next == ST_ERR);
      err_code  <= (w_next == ST_ERR) ? w_code : ERR_NONE;
    end
  end

  dlsc_apb_mstr_xfer #(
    .ADDR (ADDR)
  ) u_xfer (
    .clk        (apb_clk),
    .rst_n      (apb_rst_n),
    .start      (w_start),
    .write      (w_write),
    .addr       (BASE + ADDR'(w_off)),
    .wdata      (w_wdata),
    .xfer_done  (w_xfer_done),
    .rdata      (w_rdata),
    .apb_addr   (apb_addr),
    .apb_sel    (apb_sel),
    .apb_enable (apb_enable),
    .apb_write  (apb_write),
    .apb_wdata  (apb_wdata),
    .apb_strb   (apb_strb),
    .apb_ready  (apb_ready),
    .apb_rdata  (apb_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_dlsc_dcm_reprog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dlsc_dcm_reprog : directed + randomized bench with a clock-generator
//                      slave model and an expected-transaction reference.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dlsc_dcm_reprog;

  localparam int          ADDR     = 32;
  localparam logic [31:0] BASE     = 32'h4000_0100;
  localparam int          MD_MAX   = 4;
  localparam int          POLL_GAP = 3;
  localparam int          TIMEOUT  = 100;

  logic        apb_clk   = 1'b0;
  logic        apb_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_mult  = 8'd0;
  logic [7:0]  cmd_div   = 8'd0;
  logic        cmd_ready, busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] apb_addr, apb_wdata;
  logic        apb_sel, apb_enable, apb_write;
  logic [3:0]  apb_strb;
  logic        apb_ready = 1'b0;
  logic [31:0] apb_rdata;

  dlsc_dcm_reprog #(
    .ADDR(ADDR), .BASE(BASE), .MD_MAX(MD_MAX), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .apb_clk(apb_clk), .apb_rst_n(apb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mult(cmd_mult), .cmd_div(cmd_div),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
    .apb_wdata(apb_wdata), .apb_strb(apb_strb), .apb_ready(apb_ready), .apb_rdata(apb_rdata)
  );

  always #5 apb_clk = ~apb_clk;

  int cyc = 0;
  always @(posedge apb_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clock-generator model: status bit0 settles after a planned number of reads.
  int mode = 0;          // 0 normal, 1 never ready after enable, 2 rst_in while enabled
  int slv_delay = 0;
  int slv_cnt = 0;
  int dis_reads = 1;
  int en_reads = 1;
  bit m_en = 1'b1;
  int m_left = 0;

  always_comb begin
    apb_rdata    = '0;
    apb_rdata[1] = m_en && (mode == 2);
    apb_rdata[0] = m_en ? ((mode != 1) && (m_left <= 1)) : (m_left > 1);
  end

  always @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      apb_ready <= 1'b0;
      slv_cnt   <= 0;
      m_en      <= 1'b1;
      m_left    <= 0;
    end else if (apb_sel && apb_enable && apb_ready) begin
      apb_ready <= 1'b0;
      if (apb_write && apb_addr == BASE) begin
        m_en   <= apb_wdata[0];
        m_left <= apb_wdata[0] ? en_reads : dis_reads;
      end else if (!apb_write && apb_addr == BASE + 32'h4 && m_left > 0) begin
        m_left <= m_left - 1;
      end
    end else if (apb_sel && !apb_enable) begin
      slv_cnt   <= 0;
      apb_ready <= (slv_delay == 0);
    end else if (apb_sel && apb_enable) begin
      slv_cnt   <= slv_cnt + 1;
      apb_ready <= (slv_cnt + 1 >= slv_delay);
    end
  end

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t log_q[$];
  int sel_cnt = 0, post_sel = 0, done_cnt = 0, err_cnt = 0, accept_cnt = 0;
  int done_cyc = 0, err_cyc = 0, accept_cyc = 0, hs_cyc = 0, en_wr_cyc = 0;
  logic [1:0] err_code_seen = 2'd0;
  bit p_acc = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic p_write;

  always @(negedge apb_clk) begin
    if (!apb_rst_n) begin
      p_acc = 1'b0;
    end else begin
      txn_t t;
      if (apb_sel) sel_cnt++;
      if (apb_sel && (done_cnt + err_cnt) > 0) post_sel++;
      if (apb_sel && apb_enable) begin
        if (p_acc) begin
          chk("access_addr_stable", apb_addr, p_addr);
          chk("access_wdata_stable", apb_wdata, p_wdata);
          chk("access_write_stable", apb_write, p_write);
        end
        p_acc = !apb_ready; p_addr = apb_addr; p_wdata = apb_wdata; p_write = apb_write;
        if (apb_ready) begin
          t.w = apb_write; t.a = apb_addr; t.d = apb_wdata;
          log_q.push_back(t);
          hs_cyc = cyc;
          if (apb_write && apb_addr == BASE && apb_wdata == 32'd1) en_wr_cyc = cyc;
          chk("strb", apb_strb, apb_write ? 4'hF : 4'h0);
        end
      end else begin
        p_acc = 1'b0;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; err_code_seen = err_code; end
      if (cmd_valid && cmd_ready) begin accept_cnt++; accept_cyc = cyc; end
    end
  end

  function automatic txn_t mk(input bit w, input logic [7:0] off, input logic [31:0] dat);
    txn_t t;
    t.w = w; t.a = BASE + 32'(off); t.d = dat;
    return t;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (!cmd_ready && guard < 100) begin @(posedge apb_clk); #1; guard++; end
    chk("idle_before_cmd", cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input logic [7:0] m, input logic [7:0] d, input int md,
                         input int dly, input bit hold);
    txn_t exp_q[$];
    bit valid;
    int guard, n, bad;
    valid = (m != 8'd0) && (int'(m) + 1 <= MD_MAX * (int'(d) + 1));
    mode = md; slv_delay = dly;
    dis_reads = $urandom_range(1, 3); en_reads = $urandom_range(1, 3);
    wait_idle();
    log_q.delete();
    sel_cnt = 0; post_sel = 0; done_cnt = 0; err_cnt = 0; accept_cnt = 0; en_wr_cyc = 0;
    cmd_valid = 1'b1; cmd_mult = m; cmd_div = d;
    @(posedge apb_clk); #1;
    if (hold) begin cmd_mult = 8'($urandom); cmd_div = 8'($urandom); end
    else cmd_valid = 1'b0;
    guard = 0;
    while (!(done || err) && guard < 3000) begin
      @(posedge apb_clk); #1; guard++;
      if (hold) chk("ready_low_while_busy", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    chk("cmd_completed", done || err, 1'b1);
    repeat (6) @(posedge apb_clk);
    #1;
    chk("ready_after_cmd", cmd_ready, 1'b1);
    chk("busy_after_cmd", busy, 1'b0);
    chk("accept_count", accept_cnt, 1);
    chk("bus_idle_after_end", post_sel, 0);
    if (!valid) begin
      chk("inv_err_count", err_cnt, 1);
      chk("inv_done_count", done_cnt, 0);
      chk("inv_err_code", err_code_seen, 2'd1);
      chk("inv_err_latency", err_cyc - accept_cyc, 2);
      chk("inv_no_apb", sel_cnt, 0);
    end else begin
      exp_q.push_back(mk(1'b1, 8'h00, 32'd0));
      repeat (dis_reads) exp_q.push_back(mk(1'b0, 8'h04, 32'd0));
      exp_q.push_back(mk(1'b1, 8'h10, {24'd0, m}));
      exp_q.push_back(mk(1'b1, 8'h14, {24'd0, d}));
      exp_q.push_back(mk(1'b1, 8'h00, 32'd1));
      if (md == 0) repeat (en_reads) exp_q.push_back(mk(1'b0, 8'h04, 32'd0));
      if (md == 2) exp_q.push_back(mk(1'b0, 8'h04, 32'd0));
      n = exp_q.size();
      if (md == 1) begin
        chk("to_has_poll_reads", log_q.size() > n, 1'b1);
        bad = 0;
        for (int i = n; i < log_q.size(); i++)
          if (log_q[i].w || log_q[i].a != BASE + 32'h4) bad++;
        chk("to_tail_all_status_reads", bad, 0);
        chk("to_err_count", err_cnt, 1);
        chk("to_done_count", done_cnt, 0);
        chk("to_err_code", err_code_seen, 2'd2);
        chk("to_within_bound", (err_cyc - en_wr_cyc) <= TIMEOUT + POLL_GAP + 5, 1'b1);
      end else begin
        chk("txn_count", log_q.size(), n);
      end
      for (int i = 0; i < n && i < log_q.size(); i++) begin
        chk($sformatf("txn%0d_write", i), log_q[i].w, exp_q[i].w);
        chk($sformatf("txn%0d_addr", i), log_q[i].a, exp_q[i].a);
        if (exp_q[i].w) chk($sformatf("txn%0d_wdata", i), log_q[i].d, exp_q[i].d);
      end
      if (md == 0) begin
        chk("ok_done_count", done_cnt, 1);
        chk("ok_err_count", err_cnt, 0);
        chk("ok_done_latency", done_cyc - hs_cyc, 2);
      end else if (md == 2) begin
        chk("rst_err_count", err_cnt, 1);
        chk("rst_done_count", done_cnt, 0);
        chk("rst_err_code", err_code_seen, 2'd3);
        chk("rst_err_latency", err_cyc - hs_cyc, 2);
      end
    end
  endtask

  task automatic reset_mid();
    int guard = 0;
    mode = 0; slv_delay = 2; dis_reads = 1; en_reads = 1;
    wait_idle();
    cmd_valid = 1'b1; cmd_mult = 8'd7; cmd_div = 8'd1;
    @(posedge apb_clk); #1;
    cmd_valid = 1'b0;
    while (!(apb_sel && apb_enable && apb_addr == BASE + 32'h10) && guard < 300) begin
      @(posedge apb_clk); #1; guard++;
    end
    chk("reached_wr_mult_access", apb_sel && apb_enable && apb_addr == BASE + 32'h10, 1'b1);
    #2 apb_rst_n = 1'b0;
    #1;
    chk("rst_sel_low", apb_sel, 1'b0);
    chk("rst_enable_low", apb_enable, 1'b0);
    chk("rst_busy_low", busy, 1'b0);
    repeat (2) @(posedge apb_clk);
    #1 apb_rst_n = 1'b1;
    done_cnt = 0; err_cnt = 0;
    repeat (20) @(posedge apb_clk);
    #1;
    chk("post_rst_no_done", done_cnt, 0);
    chk("post_rst_no_err", err_cnt, 0);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_sel", apb_sel, 1'b0);
  endtask

  initial begin
    int m, d, hi;
    repeat (3) @(posedge apb_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_apb_sel", apb_sel, 1'b0);
    chk("rst_apb_enable", apb_enable, 1'b0);
    chk("rst_apb_write", apb_write, 1'b0);
    chk("rst_apb_addr", apb_addr, 32'd0);
    chk("rst_apb_wdata", apb_wdata, 32'd0);
    chk("rst_apb_strb", apb_strb, 4'd0);
    apb_rst_n = 1'b1;
    @(posedge apb_clk); #1;

    run_cmd(8'd7, 8'd1, 0, 0, 1'b0);                       // M/D = 4, boundary valid
    run_cmd(8'd0, 8'($urandom_range(0, 255)), 0, 0, 1'b0); // mult == 0
    run_cmd(8'd9, 8'd1, 0, 0, 1'b0);                       // M/D = 5
    run_cmd(8'd8, 8'd1, 0, 0, 1'b0);                       // just over the ratio
    run_cmd(8'd7, 8'd1, 1, 0, 1'b0);                       // never ready -> timeout
    run_cmd(8'd7, 8'd1, 2, 0, 1'b0);                       // rst_in during POLL_EN
    run_cmd(8'd11, 8'd3, 0, 5, 1'b1);                      // slow slave, valid held while busy

    for (int i = 0; i < 8; i++) begin
      d  = $urandom_range(0, 255);
      hi = MD_MAX * (d + 1) - 1;
      if (hi > 255) hi = 255;
      if ($urandom_range(0, 1) == 1) m = $urandom_range(1, hi);
      else m = $urandom_range(0, 255);
      run_cmd(8'(m), 8'(d), 0, $urandom_range(0, 2), 1'b0);
    end

    reset_mid();
    run_cmd(8'd7, 8'd1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
